// File: rtl/regfile_load_engine_pkg.sv
// Shared types and address helpers for the register-file load/dump engine.
package regfile_load_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DUMP,
    ST_FIN
  } state_e;

  typedef enum logic {
    OP_LOAD = 1'b0,
    OP_DUMP = 1'b1
  } op_e;

  // Address stepping wraps from hi back to lo so a block may straddle the top of the window.
  function automatic int unsigned wrap_next(input int unsigned addr, input int unsigned lo,
                                            input int unsigned hi);
    return (addr == hi) ? lo : addr + 1;
  endfunction

  function automatic logic cmd_legal(input int unsigned base, input int unsigned count,
                                     input int unsigned lo, input int unsigned hi);
    return (base >= lo) && (base <= hi) && (count <= hi - lo + 1);
  endfunction

endpackage

// File: rtl/regfile_load_outreg.sv
// Single-entry valid/ready output register: refills when empty or while being drained.
module regfile_load_outreg #(
  parameter int unsigned width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic             out_last
);

  logic             valid_q, valid_d;
  logic [width-1:0] data_q, data_d;
  logic             last_q, last_d;

  // Kept outside the next-state block so the upstream push logic never sees a false loop.
  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
      last_d  = in_last;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: rtl/regfile_load_engine.sv
// Command-driven sequencer that streams blocks into (LOAD) or out of (DUMP) a register file.
module regfile_load_engine
  import regfile_load_engine_pkg::*;
#(
  parameter int unsigned addr_width = 1,
  parameter int unsigned data_width = 1,
  parameter int unsigned lo         = 0,
  parameter int unsigned hi         = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_OP,
  input  logic [addr_width-1:0] CMD_BASE,
  input  logic [addr_width:0]   CMD_COUNT,
  input  logic                  LD_VALID,
  output logic                  LD_READY,
  input  logic [data_width-1:0] LD_DATA,
  output logic                  DP_VALID,
  input  logic                  DP_READY,
  output logic [data_width-1:0] DP_DATA,
  output logic                  DP_LAST,
  output logic [addr_width-1:0] RF_ADDR_IN,
  output logic [data_width-1:0] RF_D_IN,
  output logic                  RF_WE,
  output logic [addr_width-1:0] RF_ADDR_RD,
  input  logic [data_width-1:0] RF_D_OUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam logic [addr_width:0] CNT_ONE = (addr_width + 1)'(1);

  state_e                state_q, state_d;
  logic                  err_q, err_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [addr_width:0]   rem_q, rem_d;
  logic                  we_q, we_d;
  logic [addr_width-1:0] wa_q, wa_d;
  logic [data_width-1:0] wd_q, wd_d;

  logic ld_hs, push, push_last, ob_in_ready, ob_valid, ob_last;

  assign ld_hs     = (state_q == ST_LOAD) && (rem_q != '0) && LD_VALID;
  assign push      = (state_q == ST_DUMP) && (rem_q != '0) && ob_in_ready;
  assign push_last = (rem_q == CNT_ONE);

  // NOTE: every signal gets its hold/idle default first, so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          addr_d = CMD_BASE;
          rem_d  = CMD_COUNT;
          err_d  = 1'b0;
          if (!cmd_legal(32'(CMD_BASE), 32'(CMD_COUNT), lo, hi)) begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end else if (CMD_COUNT == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d = (CMD_OP == OP_DUMP) ? ST_DUMP : ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (ld_hs) begin
          we_d   = 1'b1;
          wa_d   = addr_q;
          wd_d   = LD_DATA;
          addr_d = addr_width'(wrap_next(32'(addr_q), lo, hi));
          rem_d  = rem_q - CNT_ONE;
          if (push_last) state_d = ST_FIN;
        end
      end
      ST_DUMP: begin
        if (push) begin
          addr_d = addr_width'(wrap_next(32'(addr_q), lo, hi));
          rem_d  = rem_q - CNT_ONE;
        end
        if (ob_valid && DP_READY && ob_last) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state updates use <= so every flop samples the pre-edge values computed above.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  regfile_load_outreg #(
    .width(data_width)
  ) u_outreg (
    .clk      (CLK),
    .rst      (RST),
    .in_valid (push),
    .in_ready (ob_in_ready),
    .in_data  (RF_D_OUT),
    .in_last  (push_last),
    .out_valid(ob_valid),
    .out_ready(DP_READY),
    .out_data (DP_DATA),
    .out_last (ob_last)
  );

  // Gated with RST so the command port reads 0 for the whole reset pulse, not just after it.
  assign CMD_READY  = (state_q == ST_IDLE) && !RST;
  assign LD_READY   = (state_q == ST_LOAD) && (rem_q != '0);
  assign DP_VALID   = ob_valid;
  assign DP_LAST    = ob_last;
  assign RF_ADDR_IN = wa_q;
  assign RF_D_IN    = wd_q;
  assign RF_WE      = we_q;
  assign RF_ADDR_RD = addr_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign DONE       = (state_q == ST_FIN);
  assign ERR        = (state_q == ST_FIN) && err_q;

endmodule

// File: tb/tb_regfile_load_engine.sv
// Directed, table-driven bench for regfile_load_engine with a behavioural register-file model.
module tb_regfile_load_engine;

  localparam logic OP_LD = 1'b0;
  localparam logic OP_DP = 1'b1;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CMD_VALID, CMD_READY, CMD_OP;
  logic [3:0] CMD_BASE;
  logic [4:0] CMD_COUNT;
  logic       LD_VALID, LD_READY;
  logic [7:0] LD_DATA;
  logic       DP_VALID, DP_READY, DP_LAST;
  logic [7:0] DP_DATA;
  logic [3:0] RF_ADDR_IN, RF_ADDR_RD;
  logic [7:0] RF_D_IN, RF_D_OUT;
  logic       RF_WE, BUSY, DONE, ERR;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [16] = '{default: 8'h00};

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (RF_WE) mem[RF_ADDR_IN] <= RF_D_IN;
  assign RF_D_OUT = mem[RF_ADDR_RD];

  regfile_load_engine #(
    .addr_width(4),
    .data_width(8),
    .lo        (2),
    .hi        (13)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_OP    (CMD_OP),
    .CMD_BASE  (CMD_BASE),
    .CMD_COUNT (CMD_COUNT),
    .LD_VALID  (LD_VALID),
    .LD_READY  (LD_READY),
    .LD_DATA   (LD_DATA),
    .DP_VALID  (DP_VALID),
    .DP_READY  (DP_READY),
    .DP_DATA   (DP_DATA),
    .DP_LAST   (DP_LAST),
    .RF_ADDR_IN(RF_ADDR_IN),
    .RF_D_IN   (RF_D_IN),
    .RF_WE     (RF_WE),
    .RF_ADDR_RD(RF_ADDR_RD),
    .RF_D_OUT  (RF_D_OUT),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  // gap: LOAD offers a word only on odd cycles; DUMP stalls 3 cycles before the third word.
  typedef struct packed {
    logic            op;
    logic [3:0]      base;
    logic [4:0]      count;
    logic            gap;
    logic            exp_err;
    logic [0:3][3:0] exp_addr;
    logic [0:3][7:0] exp_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " ctl"}, 32'({CMD_READY, LD_READY, DP_VALID, DP_LAST, RF_WE, BUSY, DONE, ERR}), 32'd0);
    check({name, " buses"}, 32'({RF_ADDR_IN, RF_ADDR_RD, RF_D_IN, DP_DATA}), 32'd0);
  endtask

  // Issue one command and watch the ports cycle by cycle until DONE (bounded at 40 cycles).
  task automatic run_vec(input vec_t v, input string name);
    int n_exp, n_wr, n_rd, done_k, first_dp, stall_cnt, ld_idx, bad;
    logic done_err, we_at_done, hs_prev, holding, held_l;
    logic [7:0] held_d;
    n_exp = v.exp_err ? 0 : int'(v.count);
    n_wr = 0; n_rd = 0; done_k = 0; first_dp = 0; stall_cnt = 0; ld_idx = 0; bad = 0;
    done_err = 1'b0; we_at_done = 1'b0; hs_prev = 1'b0; holding = 1'b0; held_l = 1'b0;
    held_d = 8'h00;
    @(negedge CLK);
    check({name, " cmd_ready idle"}, 32'(CMD_READY), 32'd1);
    CMD_VALID = 1'b1; CMD_OP = v.op; CMD_BASE = v.base; CMD_COUNT = v.count;
    for (int k = 1; k <= 40 && done_k == 0; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        CMD_VALID = 1'b0;
        check({name, " held off"}, 32'({CMD_READY, BUSY}), 32'b01);
      end
      if (RF_WE !== hs_prev) bad++;
      if (RF_WE) begin
        if (n_wr >= n_exp || RF_ADDR_IN !== v.exp_addr[n_wr] || RF_D_IN !== v.exp_data[n_wr]) bad++;
        n_wr++;
      end
      if (holding && (DP_VALID !== 1'b1 || DP_DATA !== held_d || DP_LAST !== held_l)) bad++;
      if (v.op == OP_LD && DP_VALID) bad++;
      if (v.op == OP_DP && LD_READY) bad++;
      if (DP_VALID && first_dp == 0) first_dp = k;
      if (DONE) begin
        done_k = k; done_err = ERR; we_at_done = RF_WE;
      end
      hs_prev = 1'b0; LD_VALID = 1'b0; DP_READY = 1'b1;
      if (done_k == 0 && v.op == OP_LD && ld_idx < int'(v.count) && ld_idx < 4 &&
          (!v.gap || (k % 2 == 1))) begin
        LD_VALID = 1'b1;
        LD_DATA  = v.exp_data[ld_idx];
        if (LD_READY) begin
          hs_prev = 1'b1;
          ld_idx++;
        end
      end
      if (done_k == 0 && v.gap && DP_VALID && n_rd == 2 && stall_cnt < 3) begin
        DP_READY = 1'b0;
        stall_cnt++;
      end
      holding = DP_VALID && !DP_READY;
      held_d  = DP_DATA;
      held_l  = DP_LAST;
      if (done_k == 0 && DP_VALID && DP_READY) begin
        if (n_rd >= n_exp || DP_DATA !== v.exp_data[n_rd] || DP_LAST !== (n_rd == n_exp - 1)) bad++;
        n_rd++;
      end
    end
    LD_VALID = 1'b0; DP_READY = 1'b1;
    check({name, " done seen"}, 32'(done_k != 0), 32'd1);
    check({name, " err"}, 32'(done_err), 32'(v.exp_err));
    check({name, " protocol"}, bad, 32'd0);
    if (v.op == OP_LD) begin
      check({name, " writes"}, n_wr, n_exp);
      check({name, " done with last write"}, 32'(we_at_done), 32'(n_exp != 0));
    end else begin
      check({name, " words"}, n_rd, n_exp);
      check({name, " first valid cycle"}, first_dp, (n_exp != 0) ? 32'd2 : 32'd0);
    end
    if (n_exp == 0) check({name, " quick done"}, 32'(done_k > 0 && done_k <= 2), 32'd1);
  endtask

  vec_t vecs [13];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // exp_addr / exp_data list word 0 first.
    vecs[0]  = '{op: OP_LD, base: 4'd4,  count: 5'd3,  gap: 1'b0, exp_err: 1'b0,
                 exp_addr: {4'd4, 4'd5, 4'd6, 4'd0}, exp_data: {8'hA1, 8'hA2, 8'hA3, 8'h00}};
    vecs[1]  = '{op: OP_DP, base: 4'd4,  count: 5'd3,  gap: 1'b0, exp_err: 1'b0,
                 exp_addr: {4'd4, 4'd5, 4'd6, 4'd0}, exp_data: {8'hA1, 8'hA2, 8'hA3, 8'h00}};
    vecs[2]  = '{op: OP_LD, base: 4'd12, count: 5'd4,  gap: 1'b1, exp_err: 1'b0,
                 exp_addr: {4'd12, 4'd13, 4'd2, 4'd3}, exp_data: {8'hB1, 8'hB2, 8'hB3, 8'hB4}};
    vecs[3]  = '{op: OP_DP, base: 4'd12, count: 5'd4,  gap: 1'b1, exp_err: 1'b0,
                 exp_addr: {4'd12, 4'd13, 4'd2, 4'd3}, exp_data: {8'hB1, 8'hB2, 8'hB3, 8'hB4}};
    vecs[4]  = '{op: OP_LD, base: 4'd1,  count: 5'd2,  gap: 1'b0, exp_err: 1'b1,
                 exp_addr: '0, exp_data: {8'h11, 8'h12, 8'h00, 8'h00}};
    vecs[5]  = '{op: OP_LD, base: 4'd4,  count: 5'd13, gap: 1'b0, exp_err: 1'b1,
                 exp_addr: '0, exp_data: {8'h21, 8'h22, 8'h23, 8'h24}};
    vecs[6]  = '{op: OP_DP, base: 4'd14, count: 5'd1,  gap: 1'b0, exp_err: 1'b1,
                 exp_addr: '0, exp_data: '0};
    vecs[7]  = '{op: OP_LD, base: 4'd2,  count: 5'd0,  gap: 1'b0, exp_err: 1'b0,
                 exp_addr: '0, exp_data: {8'h31, 8'h00, 8'h00, 8'h00}};
    vecs[8]  = '{op: OP_DP, base: 4'd13, count: 5'd2,  gap: 1'b0, exp_err: 1'b0,
                 exp_addr: {4'd13, 4'd2, 4'd0, 4'd0}, exp_data: {8'hB2, 8'hB3, 8'h00, 8'h00}};
    vecs[9]  = '{op: OP_DP, base: 4'd2,  count: 5'd0,  gap: 1'b0, exp_err: 1'b0,
                 exp_addr: '0, exp_data: '0};
    vecs[10] = '{op: OP_DP, base: 4'd5,  count: 5'd1,  gap: 1'b0, exp_err: 1'b0,
                 exp_addr: {4'd5, 4'd0, 4'd0, 4'd0}, exp_data: {8'hA2, 8'h00, 8'h00, 8'h00}};
    vecs[11] = '{op: OP_LD, base: 4'd13, count: 5'd1,  gap: 1'b0, exp_err: 1'b0,
                 exp_addr: {4'd13, 4'd0, 4'd0, 4'd0}, exp_data: {8'h5A, 8'h00, 8'h00, 8'h00}};
    vecs[12] = '{op: OP_DP, base: 4'd12, count: 5'd3,  gap: 1'b0, exp_err: 1'b0,
                 exp_addr: {4'd12, 4'd13, 4'd2, 4'd0}, exp_data: {8'hB1, 8'h5A, 8'hB3, 8'h00}};

    RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = 1'b0; CMD_BASE = '0; CMD_COUNT = '0;
    LD_VALID = 1'b0; LD_DATA = '0; DP_READY = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b0;
    #1;
    check("ready after reset", 32'({CMD_READY, BUSY, DONE}), 32'b100);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a 5-word LOAD at 7..11, once two words have landed.
    @(negedge CLK);
    check("midrst ready", 32'(CMD_READY), 32'd1);
    CMD_VALID = 1'b1; CMD_OP = OP_LD; CMD_BASE = 4'd7; CMD_COUNT = 5'd5;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      CMD_VALID = 1'b0;
      LD_VALID  = 1'b1;
      LD_DATA   = 8'hC0 + 8'(k);
    end
    @(negedge CLK);
    check("midrst third write pending", 32'({RF_WE, RF_ADDR_IN, RF_D_IN}), 32'({1'b1, 4'd9, 8'hC3}));
    RST = 1'b1;
    LD_VALID = 1'b0;
    #1;
    check_all_zero("midrst asserted");
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("midrst ready after release", 32'({CMD_READY, BUSY}), 32'b10);
    check("midrst mem7", 32'(mem[7]), 32'hC1);
    check("midrst mem8", 32'(mem[8]), 32'hC2);
    check("midrst mem9 untouched", 32'(mem[9]), 32'h00);
    rv = '{op: OP_DP, base: 4'd7, count: 5'd3, gap: 1'b0, exp_err: 1'b0,
           exp_addr: {4'd7, 4'd8, 4'd9, 4'd0}, exp_data: {8'hC1, 8'hC2, 8'h00, 8'h00}};
    run_vec(rv, "dump after reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
